// File: rtl/phy_header_detect_mp.sv
// phy_header_detect_mp: 802.11b PLCP header detector.
// It looks for a long or short SFD in the descrambled bit stream and then
// captures the 48-bit PLCP header. It runs a CRC-16 over the header and checks
// the SIGNAL rate code. The outputs are the decoded fields, a set of strobes
// and a saturating CRC-error counter.
module phy_header_detect_mp #(
  parameter int SFD_TIMEOUT  = 128,
  parameter int ALLOW_SHORT  = 1,
  parameter int CHECK_SIGNAL = 1,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_data_bit,
  input  logic             i_data_valid,
  input  logic             i_preamble_detected,
  input  logic             i_err_clr,
  output logic [7:0]       o_pkt_signal,
  output logic [7:0]       o_pkt_service,
  output logic [15:0]      o_pkt_len,
  output logic             o_short_preamble,
  output logic             o_pkt_header_valid,
  output logic             o_pkt_header_valid_strobe,
  output logic             o_crc_error_strobe,
  output logic             o_sfd_timeout_strobe,
  output logic [CNT_W-1:0] o_crc_err_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SFD_SEARCH,
    S_HEADER,
    S_CHECK
  } state_t;

  state_t             r_state;
  logic [15:0]        r_sr;
  logic [15:0]        r_search_cnt;
  logic [5:0]         r_bit_cnt;
  logic [15:0]        r_crc;
  logic [15:0]        r_rx_crc;
  logic [7:0]         r_signal;
  logic [7:0]         r_service;
  logic [15:0]        r_len;
  logic               r_short;
  logic               r_valid;
  logic               r_hdr_strobe;
  logic               r_crc_err_strobe;
  logic               r_timeout_strobe;
  logic [CNT_W-1:0]   r_err_cnt;

  logic [15:0]        w_next_sr;
  logic               w_long_match;
  logic               w_short_match;
  logic               w_match;
  logic [16:0]        w_search_next;
  logic               w_fb;
  logic [15:0]        w_crc_next;
  logic               w_crc_ok;
  logic               w_rate_legal;
  logic               w_rate_ok;

  // The SFD compare looks at the shift register value that includes the current bit.
  assign w_next_sr     = {r_sr[14:0], i_data_bit};
  assign w_long_match  = (w_next_sr == 16'h05CF);
  assign w_short_match = (ALLOW_SHORT != 0) && (w_next_sr == 16'hF3A0);
  assign w_match       = w_long_match | w_short_match;
  assign w_search_next = {1'b0, r_search_cnt} + 17'd1;

  // This is a CCITT CRC-16 step (x^16 + x^12 + x^5 + 1) on the incoming header bit.
  assign w_fb       = i_data_bit ^ r_crc[15];
  assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

  // The received CRC is sent inverted, so it is compared against the complement of the running value.
  assign w_crc_ok     = (r_rx_crc == ~r_crc);
  assign w_rate_legal = ((r_signal == 8'h0A) && !r_short) || (r_signal == 8'h14) ||
                        (r_signal == 8'h37) || (r_signal == 8'h6E);
  assign w_rate_ok    = (CHECK_SIGNAL == 0) || w_rate_legal;

  // The SFD shift register takes in every qualified bit, whatever the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sr <= '0;
    end else if (i_data_valid) begin
      r_sr <= w_next_sr;
    end
  end

  // Main sequencer: SFD search, header capture, CRC/rate check, strobes and error counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_search_cnt     <= '0;
      r_bit_cnt        <= '0;
      r_crc            <= '0;
      r_rx_crc         <= '0;
      r_signal         <= '0;
      r_service        <= '0;
      r_len            <= '0;
      r_short          <= 1'b0;
      r_valid          <= 1'b0;
      r_hdr_strobe     <= 1'b0;
      r_crc_err_strobe <= 1'b0;
      r_timeout_strobe <= 1'b0;
      r_err_cnt        <= '0;
    end else begin
      r_hdr_strobe     <= 1'b0;
      r_crc_err_strobe <= 1'b0;
      r_timeout_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_preamble_detected) begin
            r_state      <= S_SFD_SEARCH;
            r_search_cnt <= '0;
          end
        end
        S_SFD_SEARCH: begin
          if (i_data_valid) begin
            if (w_match) begin
              r_state   <= S_HEADER;
              r_short   <= w_short_match;
              r_valid   <= 1'b0;
              r_bit_cnt <= '0;
              r_crc     <= 16'hFFFF;
            end else if (w_search_next == 17'(SFD_TIMEOUT)) begin
              r_state          <= S_IDLE;
              r_timeout_strobe <= 1'b1;
            end else begin
              r_search_cnt <= w_search_next[15:0];
            end
          end
        end
        S_HEADER: begin
          if (i_data_valid) begin
            if (r_bit_cnt < 6'd8) begin
              r_signal[r_bit_cnt[2:0]] <= i_data_bit;
            end else if (r_bit_cnt < 6'd16) begin
              r_service[r_bit_cnt[2:0]] <= i_data_bit;
            end else if (r_bit_cnt < 6'd32) begin
              r_len[r_bit_cnt[3:0]] <= i_data_bit;
            end else begin
              r_rx_crc <= {r_rx_crc[14:0], i_data_bit};
            end
            if (r_bit_cnt < 6'd32) begin
              r_crc <= w_crc_next;
            end
            if (r_bit_cnt == 6'd47) begin
              r_state <= S_CHECK;
            end
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end
        S_CHECK: begin
          r_valid      <= w_crc_ok & w_rate_ok;
          r_hdr_strobe <= 1'b1;
          if (!w_crc_ok) begin
            r_crc_err_strobe <= 1'b1;
            if (r_err_cnt != {CNT_W{1'b1}}) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_err_clr) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign o_pkt_signal              = r_signal;
  assign o_pkt_service             = r_service;
  assign o_pkt_len                 = r_len;
  assign o_short_preamble          = r_short;
  assign o_pkt_header_valid        = r_valid;
  assign o_pkt_header_valid_strobe = r_hdr_strobe;
  assign o_crc_error_strobe        = r_crc_err_strobe;
  assign o_sfd_timeout_strobe      = r_timeout_strobe;
  assign o_crc_err_count           = r_err_cnt;
  assign o_busy                    = (r_state != S_IDLE);

endmodule

// File: tb/tb_phy_header_detect_mp.sv
// Scoreboard testbench for phy_header_detect_mp.
// The stimulus tasks push the expected result of each packet into a queue.
// A monitor process pops that queue whenever the design raises a header or timeout strobe.
module tb_phy_header_detect_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dataBit = 1'b0;
  logic        dataValid = 1'b0;
  logic        preDet = 1'b0;
  logic        preDetB = 1'b0;
  logic        errClr = 1'b0;

  logic [7:0]  sigOut, svcOut;
  logic [15:0] lenOut;
  logic        shortOut, validOut, hdrStrobe, crcStrobe, toStrobe, busyOut;
  logic [7:0]  cntOut;

  logic [7:0]  bSig, bSvc;
  logic [15:0] bLen;
  logic        bShort, bValid, bHdrStrobe, bCrcStrobe, bToStrobe, bBusy;
  logic [7:0]  bCnt;

  typedef struct {
    bit          isTimeout;
    bit          valid;
    bit          crcErr;
    bit          shortP;
    logic [7:0]  sig;
    logic [7:0]  svc;
    logic [15:0] len;
    int          count;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   modelCount = 0;
  int   cycleCnt = 0;
  int   lastBitCycle = 0;
  int   bTimeouts = 0;
  int   bHdrs = 0;

  phy_header_detect_mp #(.SFD_TIMEOUT(128), .ALLOW_SHORT(1), .CHECK_SIGNAL(1), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_data_bit(dataBit), .i_data_valid(dataValid),
    .i_preamble_detected(preDet), .i_err_clr(errClr),
    .o_pkt_signal(sigOut), .o_pkt_service(svcOut), .o_pkt_len(lenOut),
    .o_short_preamble(shortOut), .o_pkt_header_valid(validOut),
    .o_pkt_header_valid_strobe(hdrStrobe), .o_crc_error_strobe(crcStrobe),
    .o_sfd_timeout_strobe(toStrobe), .o_crc_err_count(cntOut), .o_busy(busyOut)
  );

  phy_header_detect_mp #(.SFD_TIMEOUT(128), .ALLOW_SHORT(0), .CHECK_SIGNAL(1), .CNT_W(8)) dutLongOnly (
    .i_clk(clk), .i_reset(reset), .i_data_bit(dataBit), .i_data_valid(dataValid),
    .i_preamble_detected(preDetB), .i_err_clr(errClr),
    .o_pkt_signal(bSig), .o_pkt_service(bSvc), .o_pkt_len(bLen),
    .o_short_preamble(bShort), .o_pkt_header_valid(bValid),
    .o_pkt_header_valid_strobe(bHdrStrobe), .o_crc_error_strobe(bCrcStrobe),
    .o_sfd_timeout_strobe(bToStrobe), .o_crc_err_count(bCnt), .o_busy(bBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (bToStrobe) bTimeouts <= bTimeouts + 1;
    if (bHdrStrobe) bHdrs <= bHdrs + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Golden header CRC over the 32 SIGNAL/SERVICE/LENGTH bits in transmit order (bit 0 first).
  function automatic logic [15:0] goldenCrc(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      fb = d[k] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic sendBit(input logic b, input int gap);
    dataBit   = b;
    dataValid = 1'b1;
    @(posedge clk); #1;
    lastBitCycle = cycleCnt;
    dataValid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulsePre(input bit toB);
    if (toB) preDetB = 1'b1; else preDet = 1'b1;
    @(posedge clk); #1;
    preDet  = 1'b0;
    preDetB = 1'b0;
  endtask

  // One full packet. The stimulus is 16 idle ones, a preamble lock, leadOnes search ones, the SFD and 48 header bits.
  // If abortAt >= 0, reset is pulsed after that many header bits and nothing is expected.
  task automatic applyStimulus(input bit useShort, input logic [7:0] sig, input logic [7:0] svc,
                               input logic [15:0] len, input bit corrupt, input int gap,
                               input int leadOnes, input int abortAt);
    logic [47:0] hdr;
    logic [15:0] sfd;
    logic [15:0] rx;
    exp_t        e;
    bit          rateOk;
    hdr[31:0] = {len, svc, sig};
    rx = ~goldenCrc(hdr[31:0]);
    for (int k = 32; k < 48; k++) hdr[k] = rx[47-k];
    if (corrupt) hdr[40] = ~hdr[40];
    sfd = useShort ? 16'h05CF : 16'hF3A0;
    rateOk = (sig == 8'h14) || (sig == 8'h37) || (sig == 8'h6E) || ((sig == 8'h0A) && !useShort);
    if (abortAt < 0) begin
      e.isTimeout = 1'b0;
      e.valid     = !corrupt && rateOk;
      e.crcErr    = corrupt;
      e.shortP    = useShort;
      e.sig       = sig;
      e.svc       = svc;
      e.len       = len;
      if (corrupt && modelCount < 255) modelCount++;
      e.count     = modelCount;
      expQ.push_back(e);
    end
    for (int i = 0; i < 16; i++) sendBit(1'b1, gap);
    pulsePre(1'b0);
    for (int i = 0; i < leadOnes; i++) sendBit(1'b1, gap);
    for (int i = 0; i < 16; i++) sendBit(sfd[i], 0);
    checkOutput("valid cleared at SFD", {31'd0, validOut}, 32'd0);
    checkOutput("busy in header", {31'd0, busyOut}, 32'd1);
    checkOutput("short flag latched", {31'd0, shortOut}, {31'd0, useShort});
    repeat (gap) begin @(posedge clk); #1; end
    for (int k = 0; k < 48; k++) begin
      if (k == abortAt) break;
      sendBit(hdr[k], gap);
    end
    if (abortAt >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      modelCount = 0;
      checkOutput("rst signal", {24'd0, sigOut}, 32'd0);
      checkOutput("rst service", {24'd0, svcOut}, 32'd0);
      checkOutput("rst len", {16'd0, lenOut}, 32'd0);
      checkOutput("rst flags", {26'd0, validOut, shortOut, hdrStrobe, crcStrobe, toStrobe, busyOut}, 32'd0);
      checkOutput("rst count", {24'd0, cntOut}, 32'd0);
    end else begin
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  // The monitor pairs every header or timeout strobe with the oldest expectation in the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (crcStrobe) checkOutput("crc strobe with header strobe", {31'd0, hdrStrobe}, 32'd1);
      if (hdrStrobe || toStrobe) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected strobe", {30'd0, hdrStrobe, toStrobe}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("strobe kind timeout", {31'd0, toStrobe}, {31'd0, e.isTimeout});
          if (e.isTimeout) begin
            checkOutput("timeout latency", cycleCnt, lastBitCycle);
            checkOutput("busy after timeout", {31'd0, busyOut}, 32'd0);
            checkOutput("no header strobe on timeout", {31'd0, hdrStrobe}, 32'd0);
          end else begin
            checkOutput("header latency", cycleCnt, lastBitCycle + 1);
            checkOutput("header valid", {31'd0, validOut}, {31'd0, e.valid});
            checkOutput("crc error strobe", {31'd0, crcStrobe}, {31'd0, e.crcErr});
            checkOutput("short preamble", {31'd0, shortOut}, {31'd0, e.shortP});
            checkOutput("signal", {24'd0, sigOut}, {24'd0, e.sig});
            checkOutput("service", {24'd0, svcOut}, {24'd0, e.svc});
            checkOutput("length", {16'd0, lenOut}, {16'd0, e.len});
            checkOutput("crc err count", {24'd0, cntOut}, e.count);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t        te;
    logic [7:0]  legal[4];
    logic [7:0]  rs;
    int          waitCnt;
    legal[0] = 8'h0A; legal[1] = 8'h14; legal[2] = 8'h37; legal[3] = 8'h6E;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset fields", {sigOut, svcOut, lenOut}, 32'd0);
    checkOutput("reset flags", {26'd0, validOut, shortOut, hdrStrobe, crcStrobe, toStrobe, busyOut}, 32'd0);
    checkOutput("reset count", {24'd0, cntOut}, 32'd0);

    $display("[TB] directed headers");
    applyStimulus(1'b0, 8'h0A, 8'h00, 16'h0100, 1'b0, 0, 16, -1);
    applyStimulus(1'b1, 8'h14, 8'h00, 16'h0200, 1'b0, 0, 16, -1);
    applyStimulus(1'b1, 8'h0A, 8'h04, 16'h0300, 1'b0, 0, 16, -1);
    applyStimulus(1'b0, 8'h0A, 8'h00, 16'h0100, 1'b1, 0, 16, -1);

    $display("[TB] SFD timeout");
    for (int i = 0; i < 16; i++) sendBit(1'b1, 0);
    te.isTimeout = 1'b1; te.valid = 1'b0; te.crcErr = 1'b0; te.shortP = 1'b0;
    te.sig = '0; te.svc = '0; te.len = '0; te.count = modelCount;
    expQ.push_back(te);
    pulsePre(1'b0);
    for (int i = 0; i < 127; i++) sendBit(1'b1, 0);
    checkOutput("busy before bit 128", {30'd0, busyOut, toStrobe}, 32'd2);
    sendBit(1'b1, 0);
    checkOutput("timeout strobe at bit 128", {30'd0, busyOut, toStrobe}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] SFD completing on bit 128");
    applyStimulus(1'b0, 8'h37, 8'h00, 16'h1234, 1'b0, 0, 112, -1);

    $display("[TB] sparse then back-to-back");
    applyStimulus(1'b0, 8'h6E, 8'h80, 16'h00FF, 1'b0, 2, 16, -1);
    applyStimulus(1'b1, 8'h37, 8'h01, 16'hBEEF, 1'b0, 0, 16, -1);

    $display("[TB] short SFD on long-only instance");
    for (int i = 0; i < 16; i++) sendBit(1'b1, 0);
    pulsePre(1'b1);
    for (int i = 0; i < 16; i++) sendBit(1'b1, 0);
    for (int i = 0; i < 16; i++) sendBit(rs_short_bit(i), 0);
    for (int i = 0; i < 96; i++) sendBit(1'b1, 0);
    checkOutput("long-only timeout strobe", {31'd0, bToStrobe}, 32'd1);
    @(posedge clk); #1;
    checkOutput("long-only timeouts", bTimeouts, 32'd1);
    checkOutput("long-only header strobes", bHdrs, 32'd0);
    checkOutput("long-only busy", {31'd0, bBusy}, 32'd0);

    $display("[TB] reset mid-header");
    applyStimulus(1'b0, 8'h37, 8'hA5, 16'h5A5A, 1'b0, 0, 16, 20);
    applyStimulus(1'b0, 8'h14, 8'h00, 16'h0042, 1'b0, 0, 16, -1);

    $display("[TB] randomized headers");
    for (int n = 0; n < 20; n++) begin
      rs = ($urandom_range(0, 4) == 4) ? 8'($urandom) : legal[$urandom_range(0, 3)];
      applyStimulus(1'($urandom_range(0, 1)), rs, 8'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(16, 40), -1);
    end

    $display("[TB] counter saturation");
    for (int n = 0; n < 300; n++) applyStimulus(1'b0, 8'h0A, 8'h00, 16'h0100, 1'b1, 0, 16, -1);
    checkOutput("count saturated", {24'd0, cntOut}, 32'd255);
    errClr = 1'b1;
    @(posedge clk); #1;
    errClr = 1'b0;
    modelCount = 0;
    checkOutput("count cleared", {24'd0, cntOut}, 32'd0);

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("queue drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rs_short_bit(input int i);
    logic [15:0] s;
    s = 16'h05CF;
    return s[i];
  endfunction

endmodule
